// File: rtl/constraint_sample_sched.sv
// Sequencer that fills pseudo-random candidates from a 64-bit Galois LFSR, presents each
// to an external constraint checker, and streams satisfying candidates over valid/ready.
module constraint_sample_sched #(
    parameter int CAND_W    = 185,
    parameter int CHECK_LAT = 1,
    parameter int NUM_W     = 16,
    parameter int TRY_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [63:0]       seed,
    input  logic [NUM_W-1:0]  num_samples,
    input  logic [TRY_W-1:0]  max_tries,
    output logic [CAND_W-1:0] cand,
    input  logic              chk_sat,
    output logic              smp_valid,
    input  logic              smp_ready,
    output logic [CAND_W-1:0] smp_data,
    output logic              busy,
    output logic              done,
    output logic              exhausted,
    output logic [NUM_W-1:0]  smp_count,
    output logic [TRY_W-1:0]  try_count
);

    localparam int          FILL_N    = (CAND_W + 63) / 64;
    localparam int          FW        = $clog2(FILL_N + 1);
    localparam int          LW        = (CHECK_LAT > 0) ? $clog2(CHECK_LAT + 1) : 1;
    localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

    typedef enum logic [2:0] {IDLE, FILL, CHECK, EMIT, DONE} state_t;

    state_t                state, state_next;
    logic [63:0]           lfsr, lfsr_next;
    logic [CAND_W+63:0]    cand_cat;
    logic [FW-1:0]         fill_cnt;
    logic [LW-1:0]         lat_cnt;
    logic [NUM_W-1:0]      num_q, smp_inc;
    logic [TRY_W-1:0]      max_q, try_inc;
    logic                  fill_last, check_fire, check_budget, emit_budget, xfer;

    assign lfsr_next    = (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 64'h0);
    assign cand_cat     = {cand, lfsr_next};
    assign fill_last    = (fill_cnt == FW'(FILL_N - 1));
    assign check_fire   = (state == CHECK) && (lat_cnt == LW'(CHECK_LAT));
    assign try_inc      = (try_count == '1) ? try_count : try_count + TRY_W'(1);
    assign smp_inc      = (smp_count == '1) ? smp_count : smp_count + NUM_W'(1);
    assign check_budget = !chk_sat && (max_q != '0) && (try_inc == max_q);
    // Budget is judged only after the pending sample has been handed over.
    assign emit_budget  = (max_q != '0) && (try_count >= max_q);
    assign xfer         = (state == EMIT) && smp_ready;
    assign busy         = (state != IDLE);
    assign done         = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (num_samples == '0) ? DONE : FILL;
                end
            end
            FILL: begin
                if (fill_last) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                if (check_fire) begin
                    if (chk_sat) begin
                        state_next = EMIT;
                    end else if (check_budget) begin
                        state_next = DONE;
                    end else begin
                        state_next = FILL;
                    end
                end
            end
            EMIT: begin
                if (xfer) begin
                    if (smp_inc == num_q || emit_budget) begin
                        state_next = DONE;
                    end else begin
                        state_next = FILL;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr      <= 64'h1;
            cand      <= '0;
            smp_data  <= '0;
            smp_valid <= 1'b0;
            exhausted <= 1'b0;
            smp_count <= '0;
            try_count <= '0;
            num_q     <= '0;
            max_q     <= '0;
            fill_cnt  <= '0;
            lat_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        lfsr      <= (seed == 64'h0) ? 64'h1 : seed;
                        num_q     <= num_samples;
                        max_q     <= max_tries;
                        try_count <= '0;
                        smp_count <= '0;
                        exhausted <= 1'b0;
                        fill_cnt  <= '0;
                    end
                end
                FILL: begin
                    cand     <= cand_cat[CAND_W-1:0];
                    lfsr     <= lfsr_next;
                    fill_cnt <= fill_last ? '0 : fill_cnt + FW'(1);
                    lat_cnt  <= '0;
                end
                CHECK: begin
                    if (!check_fire) begin
                        lat_cnt <= lat_cnt + LW'(1);
                    end else begin
                        lat_cnt   <= '0;
                        try_count <= try_inc;
                        if (chk_sat) begin
                            smp_data  <= cand;
                            smp_valid <= 1'b1;
                        end else if (check_budget) begin
                            exhausted <= 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (smp_ready) begin
                        smp_valid <= 1'b0;
                        smp_count <= smp_inc;
                        if (smp_inc != num_q && emit_budget) begin
                            exhausted <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_constraint_sample_sched.sv
// Scoreboard bench for constraint_sample_sched: stimulus pushes hand-computed expected
// samples into a queue, a negedge monitor pops and compares on every transfer.
module tb_constraint_sample_sched;

    localparam int CAND_W = 185;

    // Seed 1 gives LFSR states D8.., 6C.., 36.., 1B.., 0D8.., 06C.., 036.., 01B.., 00D8..
    localparam logic [CAND_W-1:0] CAND1 =
        {57'h0, 64'h6C00_0000_0000_0000, 64'h3600_0000_0000_0000};
    localparam logic [CAND_W-1:0] CAND2 =
        {57'h100_0000_0000_0000, 64'h0D80_0000_0000_0000, 64'h06C0_0000_0000_0000};
    localparam logic [CAND_W-1:0] CAND3 =
        {57'h160_0000_0000_0000, 64'h01B0_0000_0000_0000, 64'h00D8_0000_0000_0000};

    logic              clk = 1'b0;
    logic              rst, start, chk_sat, smp_ready;
    logic [63:0]       seed;
    logic [15:0]       num_samples;
    logic [31:0]       max_tries;
    logic [CAND_W-1:0] cand, smp_data;
    logic              smp_valid, busy, done, exhausted;
    logic [15:0]       smp_count;
    logic [31:0]       try_count;

    int                checks = 0;
    int                passes = 0;
    logic              valid_seen = 1'b0;
    logic [CAND_W-1:0] exp_q[$];

    constraint_sample_sched dut (
        .clk(clk), .rst(rst), .start(start), .seed(seed),
        .num_samples(num_samples), .max_tries(max_tries), .cand(cand),
        .chk_sat(chk_sat), .smp_valid(smp_valid), .smp_ready(smp_ready),
        .smp_data(smp_data), .busy(busy), .done(done), .exhausted(exhausted),
        .smp_count(smp_count), .try_count(try_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [255:0] actual,
                               input logic [255:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [63:0] s, input logic [15:0] n,
                                 input logic [31:0] t);
        seed        = s;
        num_samples = n;
        max_tries   = t;
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    task automatic waitDone(input string name, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (done) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: done not seen after %0d cycles, required within %0d",
                     name, n, budget);
        end
        tick();
        checkOutput({name, "_done_pulse"}, 256'(done), 256'(0));
        checkOutput({name, "_idle"}, 256'(busy), 256'(0));
        checkOutput({name, "_queue_empty"}, 256'(exp_q.size()), 256'(0));
    endtask

    // Monitor: every accepted sample must match the next expected entry.
    always @(negedge clk) begin
        if (!rst && smp_valid) begin
            valid_seen = 1'b1;
        end
        if (!rst && smp_valid && smp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("[TB] FAIL unexpected_sample: got %h expected no sample", smp_data);
            end else begin
                checkOutput("sample", 256'(smp_data), 256'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; seed = '0; num_samples = '0; max_tries = '0;
        chk_sat = 1'b0; smp_ready = 1'b0;
        tick();
        tick();
        checkOutput("rst_busy", 256'(busy), 256'(0));
        checkOutput("rst_done", 256'(done), 256'(0));
        checkOutput("rst_valid", 256'(smp_valid), 256'(0));
        checkOutput("rst_cand", 256'(cand), 256'(0));
        checkOutput("rst_tries", 256'(try_count), 256'(0));
        checkOutput("rst_lfsr", 256'(dut.lfsr), 256'(1));
        rst = 1'b0;
        tick();

        $display("[TB] three satisfying samples, seed 1");
        chk_sat = 1'b1; smp_ready = 1'b1;
        exp_q.push_back(CAND1); exp_q.push_back(CAND2); exp_q.push_back(CAND3);
        applyStimulus(64'h1, 16'd3, 32'd0);
        waitDone("t1", 200);
        checkOutput("t1_tries", 256'(try_count), 256'(3));
        checkOutput("t1_samples", 256'(smp_count), 256'(3));
        checkOutput("t1_exhausted", 256'(exhausted), 256'(0));
        checkOutput("t1_lfsr", 256'(dut.lfsr), 256'(64'h00D8_0000_0000_0000));

        $display("[TB] zero samples requested");
        applyStimulus(64'h1234, 16'd0, 32'd0);
        checkOutput("t3_done_now", 256'(done), 256'(1));
        waitDone("t3", 3);
        checkOutput("t3_tries", 256'(try_count), 256'(0));
        checkOutput("t3_cand", 256'(cand), 256'(CAND3));

        $display("[TB] never satisfied, budget 5");
        chk_sat = 1'b0; valid_seen = 1'b0;
        applyStimulus(64'h5, 16'd4, 32'd5);
        waitDone("t2", 200);
        checkOutput("t2_tries", 256'(try_count), 256'(5));
        checkOutput("t2_exhausted", 256'(exhausted), 256'(1));
        checkOutput("t2_samples", 256'(smp_count), 256'(0));
        checkOutput("t2_valid_seen", 256'(valid_seen), 256'(0));

        $display("[TB] budget reached while emitting");
        chk_sat = 1'b1;
        exp_q.push_back(CAND1); exp_q.push_back(CAND2);
        applyStimulus(64'h1, 16'd4, 32'd2);
        waitDone("t2b", 200);
        checkOutput("t2b_samples", 256'(smp_count), 256'(2));
        checkOutput("t2b_tries", 256'(try_count), 256'(2));
        checkOutput("t2b_exhausted", 256'(exhausted), 256'(1));

        $display("[TB] consumer stall");
        smp_ready = 1'b0;
        exp_q.push_back(CAND1);
        applyStimulus(64'h1, 16'd1, 32'd0);
        checkOutput("t4_exhausted_cleared", 256'(exhausted), 256'(0));
        begin
            int n = 0;
            while (!smp_valid && n < 50) begin
                tick();
                n++;
            end
        end
        checkOutput("t4_valid_up", 256'(smp_valid), 256'(1));
        for (int i = 0; i < 10; i++) begin
            checkOutput("t4_hold_valid", 256'(smp_valid), 256'(1));
            tick();
        end
        checkOutput("t4_hold_data", 256'(smp_data), 256'(CAND1));
        checkOutput("t4_hold_tries", 256'(try_count), 256'(1));
        checkOutput("t4_hold_lfsr", 256'(dut.lfsr), 256'(64'h3600_0000_0000_0000));
        smp_ready = 1'b1;
        waitDone("t4", 20);
        checkOutput("t4_samples", 256'(smp_count), 256'(1));

        $display("[TB] reset during fill");
        applyStimulus(64'h1, 16'd3, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("t5_busy", 256'(busy), 256'(0));
        checkOutput("t5_done", 256'(done), 256'(0));
        checkOutput("t5_tries", 256'(try_count), 256'(0));
        checkOutput("t5_samples", 256'(smp_count), 256'(0));
        checkOutput("t5_lfsr", 256'(dut.lfsr), 256'(1));
        checkOutput("t5_cand", 256'(cand), 256'(0));
        tick();

        $display("[TB] seed 0 with a start issued mid-run");
        exp_q.push_back(CAND1); exp_q.push_back(CAND2); exp_q.push_back(CAND3);
        applyStimulus(64'h0, 16'd3, 32'd0);
        tick();
        applyStimulus(64'h5, 16'd1, 32'd1);
        waitDone("t6", 200);
        checkOutput("t6_samples", 256'(smp_count), 256'(3));
        checkOutput("t6_tries", 256'(try_count), 256'(3));
        checkOutput("t6_exhausted", 256'(exhausted), 256'(0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
